// File: rtl/gift_mask_pkg.sv
// Shared definitions for the masked GIFT S-box sequencer.
//   GIFT_NIB64 / GIFT_NIB128 : nibbles per state for GIFT-64 / GIFT-128
//   SBOX_LAT_DEFAULT         : register stages in the external masked S-box
//   state_t                  : sequencer FSM states
package gift_mask_pkg;
   localparam int GIFT_NIB64       = 16;
   localparam int GIFT_NIB128      = 32;
   localparam int SBOX_LAT_DEFAULT = 2;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;
endpackage

// File: rtl/gift_sched_delay.sv
// LAT-deep {valid, idx} delay line that mirrors the S-box pipeline so a
// returning nibble can be routed back to its slot in the output shares.
//   clk, rst_n       : clock, asynchronous active-low reset
//   in_vld, in_idx   : entry pushed every cycle (valid=0 on idle cycles)
//   out_vld, out_idx : entry pushed LAT cycles earlier
module gift_sched_delay #(
   parameter int LAT  = 2,
   parameter int IDXW = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_vld,
   input  logic [IDXW-1:0] in_idx,
   output logic            out_vld,
   output logic [IDXW-1:0] out_idx
);

   logic [LAT-1:0]           vld_pipe;
   logic [LAT-1:0][IDXW-1:0] idx_pipe;

   // Shifts unconditionally: the S-box has no enable, so neither does this.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         idx_pipe <= '0;
      end else begin
         vld_pipe[0] <= in_vld;
         idx_pipe[0] <= in_idx;
         for (int i = 1; i < LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            idx_pipe[i] <= idx_pipe[i-1];
         end
      end
   end

   assign out_vld = vld_pipe[LAT-1];
   assign out_idx = idx_pipe[LAT-1];

endmodule

// File: rtl/gift_masked_sbox_sched.sv
// Streams a 3-share GIFT state nibble by nibble through one external,
// pipelined, second-order masked S-box and reassembles the output shares.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : one-cycle request, honoured only in IDLE
//   x1..x3            : input shares (nibble i at [4i+3:4i])
//   busy, done        : operation in progress / one-cycle completion pulse
//   y1..y3            : output shares, stable until the next accepted start
//   sb_x1..sb_x3      : nibble shares to the S-box (zero when not issuing)
//   sb_y1..sb_y3      : S-box result shares, SBOX_LAT cycles after issue
//   rnd_req           : nibbles remain to be issued
//   rnd_valid/rnd_ack : fresh randomness present / consumed (== issue)
module gift_masked_sbox_sched
   import gift_mask_pkg::*;
#(
   parameter int NIBBLES  = GIFT_NIB64,
   parameter int SBOX_LAT = SBOX_LAT_DEFAULT,
   parameter int IDXW     = $clog2(NIBBLES)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [4*NIBBLES-1:0] x1,
   input  logic [4*NIBBLES-1:0] x2,
   input  logic [4*NIBBLES-1:0] x3,
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES-1:0] y1,
   output logic [4*NIBBLES-1:0] y2,
   output logic [4*NIBBLES-1:0] y3,
   output logic [3:0]           sb_x1,
   output logic [3:0]           sb_x2,
   output logic [3:0]           sb_x3,
   input  logic [3:0]           sb_y1,
   input  logic [3:0]           sb_y2,
   input  logic [3:0]           sb_y3,
   output logic                 rnd_req,
   input  logic                 rnd_valid,
   output logic                 rnd_ack
);

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);
   localparam logic [IDXW:0]   LAST_CNT = (IDXW + 1)'(NIBBLES - 1);

   state_t                 state;
   logic [4*NIBBLES-1:0]   s1, s2, s3;
   logic [IDXW-1:0]        issue_idx;
   logic [IDXW:0]          rcv_cnt;
   logic                   rst_seen;   // blocks a start in the reset-release cycle
   logic                   issue, cap, last_cap;
   logic                   tail_vld;
   logic [IDXW-1:0]        tail_idx;

   assign issue   = (state == ISSUE) && rnd_valid;
   assign rnd_ack = issue;
   assign rnd_req = (state == ISSUE);

   // Idle cycles drive zero so stale share nibbles never toggle the S-box.
   assign sb_x1 = issue ? 4'(s1 >> {issue_idx, 2'b00}) : 4'h0;
   assign sb_x2 = issue ? 4'(s2 >> {issue_idx, 2'b00}) : 4'h0;
   assign sb_x3 = issue ? 4'(s3 >> {issue_idx, 2'b00}) : 4'h0;

   gift_sched_delay #(.LAT(SBOX_LAT), .IDXW(IDXW)) u_dly (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_vld  (issue),
      .in_idx  (issue_idx),
      .out_vld (tail_vld),
      .out_idx (tail_idx)
   );

   assign cap      = tail_vld && (state == ISSUE || state == DRAIN);
   // Leaving DRAIN on the final capture lets done land in the next cycle.
   assign last_cap = cap && (rcv_cnt == LAST_CNT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rst_seen  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         issue_idx <= '0;
         rcv_cnt   <= '0;
         s1        <= '0;
         s2        <= '0;
         s3        <= '0;
         y1        <= '0;
         y2        <= '0;
         y3        <= '0;
      end else begin
         rst_seen <= 1'b1;
         done     <= 1'b0;
         if (cap) begin
            y1[{tail_idx, 2'b00} +: 4] <= sb_y1;
            y2[{tail_idx, 2'b00} +: 4] <= sb_y2;
            y3[{tail_idx, 2'b00} +: 4] <= sb_y3;
            rcv_cnt <= rcv_cnt + 1'b1;
         end
         case (state)
            IDLE: if (start && rst_seen) begin
               s1        <= x1;
               s2        <= x2;
               s3        <= x3;
               issue_idx <= '0;
               rcv_cnt   <= '0;
               busy      <= 1'b1;
               state     <= ISSUE;
            end
            ISSUE: if (issue) begin
               if (issue_idx == LAST_IDX) state <= DRAIN;
               else                      issue_idx <= issue_idx + 1'b1;
            end
            DRAIN: if (last_cap) begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= FIN;
            end
            FIN: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gift_masked_sbox_sched.sv
module tb_gift_masked_sbox_sched;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start16 = 1'b0, start32 = 1'b0;
   logic         rnd_valid = 1'b0;
   logic [127:0] x1 = '0, x2 = '0, x3 = '0;

   logic        busy16, done16, req16, ack16;
   logic [63:0] y16_1, y16_2, y16_3;
   logic [3:0]  sbx16_1, sbx16_2, sbx16_3;
   logic [3:0]  s16_1 [2], s16_2 [2], s16_3 [2];

   logic         busy32, done32, req32, ack32;
   logic [127:0] y32_1, y32_2, y32_3;
   logic [3:0]   sbx32_1, sbx32_2, sbx32_3;
   logic [3:0]   s32_1 [3], s32_2 [3], s32_3 [3];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   gift_masked_sbox_sched dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16),
      .x1(x1[63:0]), .x2(x2[63:0]), .x3(x3[63:0]),
      .busy(busy16), .done(done16), .y1(y16_1), .y2(y16_2), .y3(y16_3),
      .sb_x1(sbx16_1), .sb_x2(sbx16_2), .sb_x3(sbx16_3),
      .sb_y1(s16_1[1]), .sb_y2(s16_2[1]), .sb_y3(s16_3[1]),
      .rnd_req(req16), .rnd_valid(rnd_valid), .rnd_ack(ack16));

   gift_masked_sbox_sched #(.NIBBLES(32), .SBOX_LAT(3)) dut32 (
      .clk(clk), .rst_n(rst_n), .start(start32),
      .x1(x1), .x2(x2), .x3(x3),
      .busy(busy32), .done(done32), .y1(y32_1), .y2(y32_2), .y3(y32_3),
      .sb_x1(sbx32_1), .sb_x2(sbx32_2), .sb_x3(sbx32_3),
      .sb_y1(s32_1[2]), .sb_y2(s32_2[2]), .sb_y3(s32_3[2]),
      .rnd_req(req32), .rnd_valid(rnd_valid), .rnd_ack(ack32));

   // GIFT S-box
   function automatic logic [3:0] gsb(input logic [3:0] v);
      case (v)
         4'h0: gsb = 4'h1;  4'h1: gsb = 4'ha;  4'h2: gsb = 4'h4;  4'h3: gsb = 4'hc;
         4'h4: gsb = 4'h6;  4'h5: gsb = 4'hf;  4'h6: gsb = 4'h3;  4'h7: gsb = 4'h9;
         4'h8: gsb = 4'h2;  4'h9: gsb = 4'hd;  4'ha: gsb = 4'hb;  4'hb: gsb = 4'h7;
         4'hc: gsb = 4'h5;  4'hd: gsb = 4'h0;  4'he: gsb = 4'h8;  default: gsb = 4'he;
      endcase
   endfunction

   // Stand-in for the external masked S-box: shares 2/3 pass through,
   // share 1 absorbs the S-box output so the XOR of shares is S(x).
   always @(posedge clk) begin
      s16_1[0] <= gsb(sbx16_1 ^ sbx16_2 ^ sbx16_3) ^ sbx16_2 ^ sbx16_3;
      s16_2[0] <= sbx16_2;
      s16_3[0] <= sbx16_3;
      s16_1[1] <= s16_1[0];  s16_2[1] <= s16_2[0];  s16_3[1] <= s16_3[0];
      s32_1[0] <= gsb(sbx32_1 ^ sbx32_2 ^ sbx32_3) ^ sbx32_2 ^ sbx32_3;
      s32_2[0] <= sbx32_2;
      s32_3[0] <= sbx32_3;
      s32_1[1] <= s32_1[0];  s32_2[1] <= s32_2[0];  s32_3[1] <= s32_3[0];
      s32_1[2] <= s32_1[1];  s32_2[2] <= s32_2[1];  s32_3[2] <= s32_3[1];
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Starts one operation (accepted edge = end of cycle 0), then walks
   // cycles 1..max_k sampling just after each falling edge.
   task automatic run(input bit big, input logic [127:0] a, input logic [127:0] b,
                      input logic [127:0] c, input bit toggle, input bit restart,
                      input int max_k, output int done_cyc, output int n_done,
                      output int n_ack, output int stall_bad);
      done_cyc = -1; n_done = 0; n_ack = 0; stall_bad = 0;
      @(negedge clk);
      x1 = a; x2 = b; x3 = c;
      if (big) start32 = 1'b1; else start16 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start16 = 1'b0; start32 = 1'b0;
      x1 = rnd128(); x2 = rnd128(); x3 = rnd128();
      for (int k = 1; k <= max_k; k++) begin
         rnd_valid = toggle ? k[0] : 1'b1;
         if (restart && (k == 3 || k == 19)) begin
            if (big) start32 = 1'b1; else start16 = 1'b1;
         end else begin
            start16 = 1'b0; start32 = 1'b0;
         end
         #1;
         if (big ? done32 : done16) begin
            n_done++;
            if (done_cyc < 0) done_cyc = k;
         end
         if (big ? ack32 : ack16) n_ack++;
         if (!rnd_valid && ((big ? {sbx32_1, sbx32_2, sbx32_3}
                                 : {sbx16_1, sbx16_2, sbx16_3}) != 12'h0)) stall_bad++;
         @(negedge clk);
      end
      start16 = 1'b0; start32 = 1'b0; rnd_valid = 1'b0;
   endtask

   initial begin
      int dc, nd, na, sb;
      logic [63:0] r2, r3;

      // reset state, with start and rnd_valid already high
      start16 = 1'b1; start32 = 1'b1; rnd_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy",  128'(busy16), 128'(0));
      chk("rst_done",  128'(done16), 128'(0));
      chk("rst_req",   128'({req16, req32}), 128'(0));
      chk("rst_ack",   128'({ack16, ack32}), 128'(0));
      chk("rst_sbx",   128'({sbx16_1, sbx16_2, sbx16_3}), 128'(0));
      chk("rst_y",     128'({y16_1, y16_2, y16_3}), 128'(0));

      // start held across reset release is ignored
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk); start16 = 1'b0; start32 = 1'b0;
      #1;
      chk("start_at_release", 128'({busy16, busy32, req16, req32}), 128'(0));
      chk("ack_idle", 128'({ack16, ack32}), 128'(0));

      // all-zero state
      run(1'b0, '0, '0, '0, 1'b0, 1'b0, 24, dc, nd, na, sb);
      chk("zero_done_cyc", 128'(dc), 128'(19));
      chk("zero_ndone", 128'(nd), 128'(1));
      chk("zero_y", 128'(y16_1 ^ y16_2 ^ y16_3), 128'h1111111111111111);
      chk("zero_acks", 128'(na), 128'(16));
      chk("zero_busy_after", 128'(busy16), 128'(0));

      // counting nibbles, random masks
      r2 = {$urandom, $urandom}; r3 = {$urandom, $urandom};
      run(1'b0, 128'(64'hFEDCBA9876543210 ^ r2 ^ r3), 128'(r2), 128'(r3), 1'b0, 1'b0,
          24, dc, nd, na, sb);
      chk("ramp_y", 128'(y16_1 ^ y16_2 ^ y16_3), 128'hE8057BD293F6C4A1);
      chk("ramp_acks", 128'(na), 128'(16));
      chk("ramp_done_cyc", 128'(dc), 128'(19));

      // randomness present every other cycle
      r2 = {$urandom, $urandom}; r3 = {$urandom, $urandom};
      run(1'b0, 128'(64'hFEDCBA9876543210 ^ r2 ^ r3), 128'(r2), 128'(r3), 1'b1, 1'b0,
          40, dc, nd, na, sb);
      chk("stall_y", 128'(y16_1 ^ y16_2 ^ y16_3), 128'hE8057BD293F6C4A1);
      chk("stall_done_cyc", 128'(dc), 128'(34));
      chk("stall_sbx_zero", 128'(sb), 128'(0));
      chk("stall_acks", 128'(na), 128'(16));

      // start re-pulsed mid-run and during FIN
      r2 = {$urandom, $urandom}; r3 = {$urandom, $urandom};
      run(1'b0, 128'(64'h0123456789ABCDEF ^ r2 ^ r3), 128'(r2), 128'(r3), 1'b0, 1'b1,
          26, dc, nd, na, sb);
      chk("restart_ndone", 128'(nd), 128'(1));
      chk("restart_done_cyc", 128'(dc), 128'(19));
      chk("restart_y", 128'(y16_1 ^ y16_2 ^ y16_3), 128'h1A4C6F392DB7508E);
      chk("restart_busy_after", 128'(busy16), 128'(0));

      // reset in the middle of ISSUE
      @(negedge clk);
      x1 = 128'(64'hFEDCBA9876543210); x2 = '0; x3 = '0; start16 = 1'b1;
      @(posedge clk);
      @(negedge clk); start16 = 1'b0; rnd_valid = 1'b1;
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 128'(busy16), 128'(0));
      chk("midrst_done", 128'(done16), 128'(0));
      chk("midrst_req", 128'(req16), 128'(0));
      chk("midrst_y", 128'({y16_1, y16_2, y16_3}), 128'(0));
      @(negedge clk); rst_n = 1'b1; rnd_valid = 1'b0;
      @(negedge clk);
      r2 = {$urandom, $urandom}; r3 = {$urandom, $urandom};
      run(1'b0, 128'(64'h0123456789ABCDEF ^ r2 ^ r3), 128'(r2), 128'(r3), 1'b0, 1'b0,
          24, dc, nd, na, sb);
      chk("postrst_y", 128'(y16_1 ^ y16_2 ^ y16_3), 128'h1A4C6F392DB7508E);
      chk("postrst_done_cyc", 128'(dc), 128'(19));
      chk("postrst_acks", 128'(na), 128'(16));

      // GIFT-128 configuration, 3-stage S-box
      run(1'b1, {32{4'hF}}, '0, '0, 1'b0, 1'b0, 42, dc, nd, na, sb);
      chk("g128_done_cyc", 128'(dc), 128'(36));
      chk("g128_y", y32_1 ^ y32_2 ^ y32_3, {32{4'hE}});
      chk("g128_acks", 128'(na), 128'(32));
      chk("g128_ndone", 128'(nd), 128'(1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
